// File: rtl/im_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Source encoding matches the memory mux_sel input.
package im_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } im_arb_state_t;

  localparam logic SRC_ALU   = 1'b0;
  localparam logic SRC_REG   = 1'b1;
  localparam int   IM_ADDR_W = 10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant, bit 0 = ALU, bit 1 = register path.
// Combinational, no backpressure of its own.
module rr_arb2
  import im_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req_valid;
    // On a tie the requester that did not win last time goes first.
    if (req_valid == 2'b11) begin
      grant = (last_grant == SRC_REG) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/im_arbiter.sv
// Shares the single-port IM between ALU writeback and register load/store.
// Write: 1 access cycle; read: rsp RD_LAT cycles after readEn. Ready only in IDLE.
module im_arbiter
  import im_arb_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              reg_valid,
  output logic              reg_ready,
  input  logic              reg_we,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rsp_valid,
  output logic              mem_readEn,
  output logic              mem_writeEn,
  output logic              mem_mux_sel,
  output logic [ADDR_W-1:0] mem_address,
  output logic              busy
);

  localparam int CNT_W = 2;

  im_arb_state_t    state;
  logic             last_grant;
  logic [CNT_W-1:0] lat_cnt;
  logic [1:0]       grant;
  logic             idle;

  rr_arb2 u_pick (
    .req_valid  ({reg_valid, alu_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle      = (state == IDLE);
  assign alu_ready = idle & grant[0];
  assign reg_ready = idle & grant[1];

  // Address and source are latched straight into the memory-facing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= SRC_REG;
      lat_cnt       <= '0;
      reg_rsp_valid <= 1'b0;
      mem_readEn    <= 1'b0;
      mem_writeEn   <= 1'b0;
      mem_mux_sel   <= SRC_ALU;
      mem_address   <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            busy        <= 1'b1;
            last_grant  <= grant[1] ? SRC_REG : SRC_ALU;
            mem_mux_sel <= grant[1] ? SRC_REG : SRC_ALU;
            mem_address <= grant[1] ? reg_addr : alu_addr;
            if (grant[1] && !reg_we) begin
              state      <= RD;
              mem_readEn <= 1'b1;
            end else begin
              state       <= WR;
              mem_writeEn <= 1'b1;
            end
          end
        end
        WR: begin
          state       <= IDLE;
          mem_writeEn <= 1'b0;
          busy        <= 1'b0;
        end
        RD: begin
          state         <= RD_WAIT;
          mem_readEn    <= 1'b0;
          lat_cnt       <= CNT_W'(RD_LAT - 1);
          reg_rsp_valid <= (RD_LAT == 1);
        end
        RD_WAIT: begin
          // The pulse is raised one cycle ahead so it lines up with lat_cnt == 0.
          if (lat_cnt == '0) begin
            state         <= IDLE;
            reg_rsp_valid <= 1'b0;
            busy          <= 1'b0;
          end else begin
            lat_cnt       <= lat_cnt - 1'b1;
            reg_rsp_valid <= (lat_cnt == CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
